// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: operand width, funct3/funct7 codes and the
// multiply/divide sequencer state encoding.
package riscv_m_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_M  = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } md_state_e;

endpackage

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step
// on the double-width {hi,lo} accumulator.
module muldiv_iter_step #(
    parameter int XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_next
);

    logic [XLEN:0]      sum_s;
    logic [XLEN+1:0]    diff_s;
    logic [2*XLEN-1:0]  shl_s;

    // single-step datapath; the bit shifted out of rem takes part in the trial subtract
    always_comb begin
        sum_s    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
        shl_s    = {acc[2*XLEN-2:0], 1'b0};
        diff_s   = {1'b0, acc[2*XLEN-1], shl_s[2*XLEN-1:XLEN]} - {2'b00, operand};
        acc_next = '0;
        if (is_div) begin
            if (!diff_s[XLEN+1]) begin
                acc_next = {diff_s[XLEN-1:0], shl_s[XLEN-1:1], 1'b1};
            end else begin
                acc_next = shl_s;
            end
        end else begin
            if (acc[0]) begin
                acc_next = {sum_s, acc[XLEN-1:1]};
            end else begin
                acc_next = {1'b0, acc[2*XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: start decode with special-case
// bypass, XLEN radix-2 iterations, one sign fix-up cycle, one-cycle done pulse.
module muldiv_sequencer
    import riscv_m_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [XLEN-1:0]  result_o
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e          state_r, state_nxt_s;
    logic [2:0]         f3_r;
    logic [2*XLEN-1:0]  acc_r, acc_nxt_s, prod_s;
    logic [XLEN-1:0]    opnd_r, result_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               neg_r, busy_r, done_r;

    logic               is_div_in_s, a_signed_s, b_signed_s, sign_a_s, sign_b_s;
    logic               b_zero_s, ovf_s, special_s, accept_s;
    logic [XLEN-1:0]    abs_a_s, abs_b_s, special_val_s, fix_val_s, lo_s, hi_s;

    // request decode: operand signs, magnitudes and the divide special cases
    always_comb begin
        is_div_in_s = funct3_i[2];
        a_signed_s  = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                      (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
        b_signed_s  = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
        sign_a_s    = a_signed_s & rs1_data_i[XLEN-1];
        sign_b_s    = b_signed_s & rs2_data_i[XLEN-1];
        abs_a_s     = sign_a_s ? -rs1_data_i : rs1_data_i;
        abs_b_s     = sign_b_s ? -rs2_data_i : rs2_data_i;
        b_zero_s    = (rs2_data_i == '0);
        ovf_s       = b_signed_s & (rs1_data_i == MIN_NEG) & (rs2_data_i == '1);
        special_s   = is_div_in_s & (b_zero_s | ovf_s);
        accept_s    = start_i & ((state_r == IDLE) | (state_r == DONE));
        if (b_zero_s) begin
            special_val_s = funct3_i[1] ? rs1_data_i : '1;
        end else begin
            special_val_s = funct3_i[1] ? '0 : MIN_NEG;
        end
    end

    muldiv_iter_step #(.XLEN(XLEN)) u_step (
        .is_div   (f3_r[2]),
        .acc      (acc_r),
        .operand  (opnd_r),
        .acc_next (acc_nxt_s)
    );

    // sign fix-up and result selection used in the FIX cycle
    always_comb begin
        prod_s = neg_r ? -acc_r : acc_r;
        lo_s   = neg_r ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
        hi_s   = neg_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
        case (f3_r)
            F3_MUL:                        fix_val_s = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fix_val_s = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               fix_val_s = lo_s;
            default:                       fix_val_s = hi_s;
        endcase
    end

    // next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start_i) begin
                    state_nxt_s = special_s ? DONE : CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == '0) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FIX:     state_nxt_s = DONE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // operand latch, iteration accumulator, counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f3_r     <= 3'b000;
            acc_r    <= '0;
            opnd_r   <= '0;
            cnt_r    <= '0;
            neg_r    <= 1'b0;
            result_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                f3_r   <= funct3_i;
                cnt_r  <= CNT_W'(XLEN - 1);
                acc_r  <= {{XLEN{1'b0}}, (is_div_in_s ? abs_a_s : abs_b_s)};
                opnd_r <= is_div_in_s ? abs_b_s : abs_a_s;
                // remainder follows the dividend; everything else follows the sign product
                neg_r  <= (is_div_in_s & funct3_i[1]) ? sign_a_s : (sign_a_s ^ sign_b_s);
                if (special_s) begin
                    result_r <= special_val_s;
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                end else begin
                    busy_r   <= 1'b1;
                end
            end else if (state_r == CALC) begin
                acc_r <= acc_nxt_s;
                cnt_r <= cnt_r - CNT_W'(1);
            end else if (state_r == FIX) begin
                result_r <= fix_val_s;
                done_r   <= 1'b1;
                busy_r   <= 1'b0;
            end
        end
    end

    assign busy_o   = busy_r | ((state_r == IDLE) & start_i & ~special_s);
    assign done_o   = done_r;
    assign result_o = result_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, back-to-back,
// ignored restart, async reset abort, and random ops against an arithmetic model.
module tb_muldiv_sequencer;

    localparam int XLEN = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start_i;
    logic [2:0]       funct3_i;
    logic [XLEN-1:0]  rs1_data_i, rs2_data_i;
    logic             busy_o, done_o;
    logic [XLEN-1:0]  result_o;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .funct3_i   (funct3_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && ((b == 32'd0) ||
               (((f3 == 3'b100) || (f3 == 3'b110)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    endfunction

    // Reference semantics from plain wide arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint     sa64, sb64, ub64;
        logic [63:0] p;
        int         sa, sb;
        sa64 = longint'($signed(a));
        sb64 = longint'($signed(b));
        ub64 = longint'({32'd0, b});
        sa = a;
        sb = b;
        case (f3)
            3'b000: begin p = 64'(sa64 * sb64); return p[31:0]; end
            3'b001: begin p = 64'(sa64 * sb64); return p[63:32]; end
            3'b010: begin p = 64'(sa64 * ub64); return p[63:32]; end
            3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Drive a request at a negedge; busy_o must follow start_i only from IDLE for normal ops
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit from_idle, input string name);
        bit sp;
        sp = is_special(f3, a, b);
        start_i    = 1'b1;
        funct3_i   = f3;
        rs1_data_i = a;
        rs2_data_i = b;
        #1;
        check({name, " issue busy"}, 64'(busy_o), 64'(from_idle && !sp));
    endtask

    // Follow the operation to done_o; optionally pulse start_i mid-flight
    task automatic wait_done(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp, input string name, input int pulse_at);
        bit sp;
        int edges;
        int busy_cnt;
        bit seen;
        sp = is_special(f3, a, b);
        edges = 0;
        busy_cnt = 0;
        seen = 1'b0;
        while (!seen && edges < 60) begin
            @(posedge clk);
            edges++;
            #1;
            start_i    = (edges == pulse_at);
            funct3_i   = 3'($urandom);
            rs1_data_i = $urandom;
            rs2_data_i = $urandom;
            @(negedge clk);
            if (done_o) seen = 1'b1;
            else if (busy_o) busy_cnt++;
        end
        check({name, " latency"}, 64'(edges), 64'(sp ? 1 : XLEN + 2));
        check({name, " busy cycles"}, 64'(busy_cnt), 64'(sp ? 0 : XLEN + 1));
        check({name, " result"}, 64'(result_o), 64'(exp));
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        issue(f3, a, b, 1'b1, name);
        wait_done(f3, a, b, exp, name, -1);
        @(negedge clk);
        check({name, " done pulse"}, 64'(done_o), 64'd0);
        check({name, " hold"}, 64'(result_o), 64'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;
        int bcount;
        logic [2:0]  f3;
        logic [31:0] a, b;

        vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
        vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
        vecs.push_back('{3'b101, 32'd100,        32'd7,         32'd14});
        vecs.push_back('{3'b111, 32'd100,        32'd7,         32'd2});
        vecs.push_back('{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF});
        vecs.push_back('{3'b111, 32'd5,          32'd0,         32'd5});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
        vecs.push_back('{3'b100, 32'd7,          32'd0,         32'hFFFF_FFFF});

        reset = 1'b1; start_i = 1'b0; funct3_i = 3'b000; rs1_data_i = '0; rs2_data_i = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset done", 64'(done_o), 64'd0);
        check("reset result", 64'(result_o), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // back-to-back: new ops issued in the DONE cycle
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b1, "b2b first");
        wait_done(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "b2b first", -1);
        issue(3'b101, 32'd100, 32'd7, 1'b0, "b2b second");
        wait_done(3'b101, 32'd100, 32'd7, 32'd14, "b2b second", -1);
        issue(3'b111, 32'd5, 32'd0, 1'b0, "b2b special");
        wait_done(3'b111, 32'd5, 32'd0, 32'd5, "b2b special", -1);
        @(negedge clk);
        check("b2b final done pulse", 64'(done_o), 64'd0);

        // start_i during CALC is ignored
        issue(3'b000, 32'h0001_2345, 32'h0000_0777, 1'b1, "ignored restart");
        wait_done(3'b000, 32'h0001_2345, 32'h0000_0777,
                  ref_model(3'b000, 32'h0001_2345, 32'h0000_0777), "ignored restart", 5);
        @(negedge clk);
        check("ignored restart done pulse", 64'(done_o), 64'd0);

        // asynchronous reset in the middle of CALC
        issue(3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, "reset abort");
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset busy", 64'(busy_o), 64'd0);
        check("async reset done", 64'(done_o), 64'd0);
        check("async reset result", 64'(result_o), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        bcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) dcount++;
            if (busy_o) bcount++;
        end
        check("no done after abort", 64'(dcount), 64'd0);
        check("no busy after abort", 64'(bcount), 64'd0);
        run_op(3'b000, 32'd3, 32'd4, 32'd12, "mul after reset");

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'd1;
                3: a = 32'h8000_0000;
                default: ;
            endcase
            run_op(f3, a, b, ref_model(f3, a, b), $sformatf("rnd%0d f3=%0d a=%h b=%h", i, f3, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its own sequencing FSM. It sits beside the main ALU in the execute stage.
- The main control unit decodes a funct7=0000001 R-type instruction and pulses start_i. The block stalls the core via busy_o until result_o is valid.
- One radix-2 step per clock (shift-add for multiply, restoring for divide). Sign fix-up is applied in a final cycle.

Parameters:
- XLEN, 32, operand/result width; must be even and at least 4.
- CNT_W, $clog2(XLEN), width of the iteration counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_i  input  1  request; sampled only in IDLE or DONE.
- funct3_i  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data_i  input  XLEN  operand A (multiplicand/dividend).
- rs2_data_i  input  XLEN  operand B (multiplier/divisor).
- busy_o  output  1  stall request to the core.
- done_o  output  1  one-cycle pulse; result_o is valid in that cycle.
- result_o  output  XLEN  result; held until the next accepted start.

Behaviour:
- Reset: asynchronous and active-high, per the already-decided line. Asserting it forces state=IDLE and clears busy_o, done_o, result_o, the counter and all internal registers to 0. Reset mid-operation aborts the operation; no done_o is issued.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start_i=1:
  - Latch funct3_i and both operands.
  - Compute operand signs: A is signed for MULH, MULHSU, DIV, REM; B is signed for MULH, DIV, REM.
  - Load absolute values, load counter=XLEN-1, go to CALC.
- Special cases (decided in the same start cycle; go directly to DONE, skip CALC/FIX):
  - DIV/DIVU with B=0: quotient = all ones.
  - REM/REMU with B=0: remainder = A.
  - DIV with A=100..0 and B=all ones: quotient = 100..0.
  - REM with A=100..0 and B=all ones: remainder = 0.
- CALC: one iteration per clock; counter decrements.
  - Multiply: 2*XLEN product register. If the LSB of the multiplier is 1, add the multiplicand into the upper half, then shift right by 1.
  - Divide: {rem,quot} shifted left by 1. Trial-subtract the divisor from rem; if non-negative, keep the difference and set quot LSB=1.
  - When counter==0 at a clock edge, go to FIX.
- FIX (1 cycle):
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Select: MUL = low half; MULH/MULHSU/MULHU = high half; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register the selected value into result_o and go to DONE.
- DONE: done_o=1 for exactly one cycle. Next state is IDLE, or CALC/DONE if start_i=1 (back-to-back issue allowed).
- busy_o:
  - Registered; 1 in CALC and FIX, 0 in IDLE and DONE.
  - In addition, busy_o = start_i combinationally in IDLE, unless a special case applies, so the core stalls in the issue cycle.
- Latency, counted in clock edges after the start edge:
  - Normal: done_o high in the cycle after edge XLEN+1, i.e. XLEN+2 cycles from start (34 at XLEN=32).
  - Special case: done_o high in the cycle after the start edge.
- start_i while in CALC/FIX is ignored. Operand/funct3 changes after acceptance have no effect.
- Arithmetic is modulo 2^XLEN (2^(2*XLEN) for the product). No exceptions are raised.

Decomposition:
- Shared package riscv_m_pkg holds:
  - XLEN default.
  - funct3 localparams (F3_MUL … F3_REMU).
  - the M-extension funct7 constant 7'b0000001.
  - the state encoding (IDLE=2'b00, CALC=2'b01, FIX=2'b10, DONE=2'b11).
- One natural sub-module, muldiv_iter_step: combinational single-iteration step.
  - Inputs: mode, product/remainder-quotient register, operand.
  - Output: next register value.
  - The FSM, counter and sign/fix-up logic stay in muldiv_sequencer.

Test Plan:
- MUL, A=7, B=0xFFFFFFFD (-3): busy_o high for 33 cycles, then done_o pulse with result_o=0xFFFFFFEB, 34 cycles after the start edge.
- MULH, A=B=0x80000000 → 0x40000000. MULHU, A=B=0xFFFFFFFF → 0xFFFFFFFE. MULHSU, A=0xFFFFFFFF, B=2 → 0xFFFFFFFF.
- DIV, A=0xFFFFFFF9 (-7), B=2 → 0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF. DIVU, A=100, B=7 → 14. REMU on the same operands → 2.
- DIVU, A=5, B=0 → 0xFFFFFFFF. REMU, A=5, B=0 → 5. DIV, A=0x80000000, B=0xFFFFFFFF → 0x80000000. Each of these raises done_o one cycle after start, with busy_o never asserted.
- Back-to-back issue and ignored restart:
  - start_i held high in the DONE cycle with a new op: the new op is accepted and the correct second result arrives 34 cycles later.
  - start_i pulsed during CALC: ignored; the first result is unchanged.
- Reset asserted mid-CALC (cycle 10), asynchronously between edges:
  - busy_o, done_o and result_o go to 0 immediately; no done_o follows.
  - A new MUL 3*4 after reset release gives 12.
